mgmt_data_channel_target: RTL and testbench

- Target-side counterpart of the LTPI management data-channel controller.
- Captures data-channel requests arriving from the LTPI PHY RX path and issues them to the local management bus through a valid/ready handshake.
- Collects the local response and places it on the PHY TX payload, aligned to operational frame boundaries.
- Sits between the LTPI PHY management/frame logic and the target-side register/bus bridge.

---
 rtl/mgmt_data_channel_target.sv | 184 ++++++++++++++++++
 tb/tb_mgmt_data_channel_target.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_data_channel_target.sv
// LTPI management data-channel target: RX request -> local bus -> TX response.
// Optional local response timeout enabled by MGMT_DC_TARGET_TIMEOUT_EN.
package mgmt_dc_pkg;
    typedef struct packed {
        logic [7:0]  tag;
        logic [3:0]  command;
        logic [15:0] address;
        logic [3:0]  byte_en;
        logic [31:0] data;
        logic        operation_status;
    } Data_channel_payload_t;

    typedef enum logic [3:0] {
        link_detect_st,
        link_speed_st,
        advertise_st,
        configure_st,
        accept_st,
        operational_st,
        link_lost_st
    } link_state_t;

    localparam logic [3:0] CMD_READ     = 4'h0;
    localparam logic [3:0] CMD_WRITE    = 4'h1;
    localparam logic [3:0] CRC_ERROR    = 4'hE;
    localparam logic [3:0] FRAME_LENGTH = 4'd15;
endpackage

module mgmt_data_channel_target
    import mgmt_dc_pkg::*;
#(
    parameter int HOLD_FRAMES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  Data_channel_payload_t payload_i,
    input  logic                  payload_i_valid,
    input  logic                  frm_crc_error,
    output logic                  req_valid,
    input  logic                  req_ready,
    output Data_channel_payload_t req_data_channel,
    input  logic                  res_valid,
    output logic                  res_ack,
    input  Data_channel_payload_t res_data_channel,
    output Data_channel_payload_t res_payload_o,
    output logic                  payload_o_valid,
    input  logic [3:0]            tx_frm_offset,
    input  link_state_t           local_link_state,
    input  logic                  data_channel_rst,
    output logic [7:0]            rx_drop_cnt
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_RES, TX_ALIGN, TX_HOLD} state_t;

    localparam logic [3:0] HOLD = 4'(HOLD_FRAMES);

    state_t                state;
    logic                  payload_i_valid_ff;
    logic                  frm_crc_error_ff;
    logic [3:0]            frm_cnt;
    logic [3:0]            offset_ff;
    Data_channel_payload_t resp;

    logic rx_new, link_up, boundary, bnd_edge;
    assign rx_new   = payload_i_valid & ~payload_i_valid_ff;
    assign link_up  = (local_link_state == operational_st);
    assign boundary = (tx_frm_offset == FRAME_LENGTH);
    assign bnd_edge = boundary & (offset_ff != FRAME_LENGTH);

`ifdef MGMT_DC_TARGET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]         to_cnt;
    logic                  to_hit;
    Data_channel_payload_t to_resp;
    assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    always_comb begin
        to_resp                  = req_data_channel;
        to_resp.data             = '0;
        to_resp.operation_status = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset || data_channel_rst) begin
            state              <= IDLE;
            req_valid          <= 1'b0;
            req_data_channel   <= '0;
            res_ack            <= 1'b0;
            res_payload_o      <= '0;
            payload_o_valid    <= 1'b0;
            rx_drop_cnt        <= '0;
            payload_i_valid_ff <= 1'b0;
            frm_crc_error_ff   <= 1'b0;
            frm_cnt            <= '0;
            offset_ff          <= '0;
            resp               <= '0;
`ifdef MGMT_DC_TARGET_TIMEOUT_EN
            to_cnt             <= '0;
`endif
        end else begin
            payload_i_valid_ff <= payload_i_valid;
            frm_crc_error_ff   <= frm_crc_error;
            offset_ff          <= tx_frm_offset;
            res_ack            <= 1'b0;
            if (!link_up) begin
                state           <= IDLE;
                req_valid       <= 1'b0;
                payload_o_valid <= 1'b0;
                res_payload_o   <= '0;
            end else begin
                if (rx_new && state != IDLE && rx_drop_cnt != 8'hFF)
                    rx_drop_cnt <= rx_drop_cnt + 8'd1;
`ifdef MGMT_DC_TARGET_TIMEOUT_EN
                if (state == REQ || state == WAIT_RES)
                    to_cnt <= to_cnt + TW'(1);
`endif
                unique case (state)
                    IDLE: begin
                        if (rx_new && !frm_crc_error_ff) begin
                            req_data_channel <= payload_i;
                            req_valid        <= 1'b1;
                            state            <= REQ;
`ifdef MGMT_DC_TARGET_TIMEOUT_EN
                            to_cnt           <= '0;
`endif
                        end else if (rx_new) begin
                            resp                  <= payload_i;
                            resp.command          <= CRC_ERROR;
                            resp.operation_status <= 1'b1;
                            state                 <= TX_ALIGN;
                        end
                    end
                    REQ: begin
                        if (req_ready) begin
                            req_valid <= 1'b0;
                            state     <= WAIT_RES;
                        end
`ifdef MGMT_DC_TARGET_TIMEOUT_EN
                        else if (to_hit) begin
                            req_valid <= 1'b0;
                            resp      <= to_resp;
                            state     <= TX_ALIGN;
                        end
`endif
                    end
                    WAIT_RES: begin
                        // Echo the request tag regardless of what the bus returns
                        if (res_valid) begin
                            resp     <= res_data_channel;
                            resp.tag <= req_data_channel.tag;
                            res_ack  <= 1'b1;
                            state    <= TX_ALIGN;
                        end
`ifdef MGMT_DC_TARGET_TIMEOUT_EN
                        else if (to_hit) begin
                            resp  <= to_resp;
                            state <= TX_ALIGN;
                        end
`endif
                    end
                    TX_ALIGN: begin
                        if (boundary) begin
                            payload_o_valid <= 1'b1;
                            res_payload_o   <= resp;
                            frm_cnt         <= '0;
                            state           <= TX_HOLD;
                        end
                    end
                    TX_HOLD: begin
                        if (bnd_edge) begin
                            frm_cnt <= frm_cnt + 4'd1;
                            if (frm_cnt + 4'd1 == HOLD) begin
                                payload_o_valid <= 1'b0;
                                res_payload_o   <= '0;
                                state           <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mgmt_data_channel_target.sv
// Scoreboard bench for mgmt_data_channel_target; timeout scenario runs when
// MGMT_DC_TARGET_TIMEOUT_EN is defined.
module tb_mgmt_data_channel_target;
    import mgmt_dc_pkg::*;

    localparam int HOLD   = 2;
    localparam int TMO    = 16;
    localparam int PERIOD = 16 * HOLD;

    logic                  clk = 1'b0;
    logic                  reset;
    Data_channel_payload_t payload_i;
    logic                  payload_i_valid;
    logic                  frm_crc_error;
    logic                  req_valid;
    logic                  req_ready;
    Data_channel_payload_t req_data_channel;
    logic                  res_valid;
    logic                  res_ack;
    Data_channel_payload_t res_data_channel;
    Data_channel_payload_t res_payload_o;
    logic                  payload_o_valid;
    logic [3:0]            tx_frm_offset = 4'd0;
    link_state_t           local_link_state;
    logic                  data_channel_rst;
    logic [7:0]            rx_drop_cnt;

    Data_channel_payload_t exp_q[$];
    int total = 0;
    int bad = 0;
    int xfer_cnt = 0;
    int ack_cnt = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    // Free-running TX frame: offset 0..15, boundary when offset==15
    always @(posedge clk) begin
        #2;
        tx_frm_offset = (tx_frm_offset == 4'd15) ? 4'd0 : tx_frm_offset + 4'd1;
    end

    always @(negedge clk) begin
        if (req_valid && req_ready) xfer_cnt++;
        if (res_ack) ack_cnt++;
    end

    mgmt_data_channel_target #(
        .HOLD_FRAMES(HOLD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .payload_i(payload_i),
        .payload_i_valid(payload_i_valid),
        .frm_crc_error(frm_crc_error),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data_channel(req_data_channel),
        .res_valid(res_valid),
        .res_ack(res_ack),
        .res_data_channel(res_data_channel),
        .res_payload_o(res_payload_o),
        .payload_o_valid(payload_o_valid),
        .tx_frm_offset(tx_frm_offset),
        .local_link_state(local_link_state),
        .data_channel_rst(data_channel_rst),
        .rx_drop_cnt(rx_drop_cnt)
    );

    function automatic Data_channel_payload_t mk(input logic [7:0] tag,
                                                 input logic [3:0] cmd,
                                                 input logic [15:0] addr,
                                                 input logic [31:0] data,
                                                 input logic st);
        Data_channel_payload_t p;
        p.tag = tag;
        p.command = cmd;
        p.address = addr;
        p.byte_en = 4'hF;
        p.data = data;
        p.operation_status = st;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one step after the edge that sees the rising payload_i_valid
    task automatic send_rx(input Data_channel_payload_t p, input logic crc);
        frm_crc_error = crc;
        tick();
        payload_i = p;
        payload_i_valid = 1'b1;
        tick();
        payload_i_valid = 1'b0;
        frm_crc_error = 1'b0;
    endtask

    task automatic handshake();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
    endtask

    // Drives a local response and pushes what the TX side must carry
    task automatic respond(input Data_channel_payload_t r, input logic [7:0] tag);
        Data_channel_payload_t e;
        e = r;
        e.tag = tag;
        exp_q.push_back(e);
        res_data_channel = r;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (payload_o_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_fall(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (payload_o_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        total++;
        if (req_valid !== 1'b0 || res_ack !== 1'b0 || payload_o_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl got rv=%b ack=%b pv=%b want 0", req_valid, res_ack, payload_o_valid);
        end
        total++;
        if (res_payload_o !== '0 || req_data_channel !== '0) begin
            bad++;
            $display("FAIL reset_data got %h/%h want 0", res_payload_o, req_data_channel);
        end
        total++;
        if (rx_drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_drop got %0d want 0", rx_drop_cnt);
        end
    endtask

    task automatic test_write();
        Data_channel_payload_t p, e;
        int x0, a0, n;
        bit ok;
        p = mk(8'd5, CMD_WRITE, 16'h0010, 32'hDEADBEEF, 1'b0);
        x0 = xfer_cnt;
        a0 = ack_cnt;
        send_rx(p, 1'b0);
        total++;
        if (req_valid !== 1'b1) begin
            bad++;
            $display("FAIL wr_req_valid got %b want 1", req_valid);
        end
        total++;
        if (req_data_channel !== p) begin
            bad++;
            $display("FAIL wr_req_data got %h want %h", req_data_channel, p);
        end
        handshake();
        total++;
        if (req_valid !== 1'b0) begin
            bad++;
            $display("FAIL wr_req_drop got %b want 0", req_valid);
        end
        repeat (2) tick();
        respond(mk(8'h77, CMD_WRITE, 16'h0010, 32'h0000_1234, 1'b0), 8'd5);
        total++;
        if (res_ack !== 1'b1) begin
            bad++;
            $display("FAIL wr_ack got %b want 1", res_ack);
        end
        tick();
        total++;
        if (res_ack !== 1'b0) begin
            bad++;
            $display("FAIL wr_ack_pulse got %b want 0", res_ack);
        end
        wait_rise(ok);
        total++;
        if (!ok || tx_frm_offset !== FRAME_LENGTH) begin
            bad++;
            $display("FAIL wr_align got ok=%0d off=%0d want 1/15", ok, tx_frm_offset);
        end
        e = exp_q.pop_front();
        total++;
        if (res_payload_o !== e) begin
            bad++;
            $display("FAIL wr_payload got %h want %h", res_payload_o, e);
        end
        wait_fall(n, ok);
        total++;
        if (!ok || n != PERIOD) begin
            bad++;
            $display("FAIL wr_hold got %0d want %0d", n, PERIOD);
        end
        total++;
        if (res_payload_o !== '0) begin
            bad++;
            $display("FAIL wr_clear got %h want 0", res_payload_o);
        end
        total++;
        if (xfer_cnt - x0 != 1 || ack_cnt - a0 != 1) begin
            bad++;
            $display("FAIL wr_counts got xfer=%0d ack=%0d want 1/1", xfer_cnt - x0, ack_cnt - a0);
        end
    endtask

    task automatic test_crc();
        Data_channel_payload_t p, e;
        int x0, n;
        bit ok;
        p = mk(8'h2A, CMD_READ, 16'h0044, 32'hCAFE_F00D, 1'b0);
        e = p;
        e.command = CRC_ERROR;
        e.operation_status = 1'b1;
        exp_q.push_back(e);
        x0 = xfer_cnt;
        send_rx(p, 1'b1);
        total++;
        if (req_valid !== 1'b0) begin
            bad++;
            $display("FAIL crc_no_req got %b want 0", req_valid);
        end
        wait_rise(ok);
        total++;
        if (!ok || tx_frm_offset !== FRAME_LENGTH) begin
            bad++;
            $display("FAIL crc_align got ok=%0d off=%0d want 1/15", ok, tx_frm_offset);
        end
        e = exp_q.pop_front();
        total++;
        if (res_payload_o !== e) begin
            bad++;
            $display("FAIL crc_payload got %h want %h", res_payload_o, e);
        end
        wait_fall(n, ok);
        total++;
        if (!ok || xfer_cnt != x0) begin
            bad++;
            $display("FAIL crc_bus got xfer=%0d want 0 ok=%0d", xfer_cnt - x0, ok);
        end
    endtask

    task automatic test_busy_drop();
        Data_channel_payload_t e;
        int x0, n;
        bit ok;
        send_rx(mk(8'd9, CMD_READ, 16'h0100, 32'h0, 1'b0), 1'b0);
        handshake();
        x0 = xfer_cnt;
        for (int i = 0; i < 3; i++)
            send_rx(mk(8'h30 + 8'(i), CMD_WRITE, 16'h0200, 32'h1, 1'b0), 1'b0);
        exp_drop += 3;
        tick();
        total++;
        if (rx_drop_cnt !== 8'(exp_drop)) begin
            bad++;
            $display("FAIL busy_drop3 got %0d want %0d", rx_drop_cnt, exp_drop);
        end
        total++;
        if (xfer_cnt != x0 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL busy_bus got xfer=%0d rv=%b want 0/0", xfer_cnt - x0, req_valid);
        end
        for (int i = 0; i < 300; i++)
            send_rx(mk(8'(i), CMD_WRITE, 16'(i), 32'(i), 1'b0), 1'b0);
        exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
        tick();
        total++;
        if (rx_drop_cnt !== 8'(exp_drop)) begin
            bad++;
            $display("FAIL busy_sat got %0d want %0d", rx_drop_cnt, exp_drop);
        end
        respond(mk(8'h01, CMD_READ, 16'h0100, 32'h5555_AAAA, 1'b0), 8'd9);
        wait_rise(ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || res_payload_o !== e) begin
            bad++;
            $display("FAIL busy_resp got %h want %h ok=%0d", res_payload_o, e, ok);
        end
        wait_fall(n, ok);
    endtask

    task automatic test_link_loss();
        Data_channel_payload_t p, e;
        int n;
        bit ok;
        send_rx(mk(8'h11, CMD_READ, 16'h0300, 32'h0, 1'b0), 1'b0);
        handshake();
        respond(mk(8'h11, CMD_READ, 16'h0300, 32'h0BAD_0BAD, 1'b0), 8'h11);
        wait_rise(ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || res_payload_o !== e) begin
            bad++;
            $display("FAIL link_pre got %h want %h ok=%0d", res_payload_o, e, ok);
        end
        repeat (3) tick();
        local_link_state = link_lost_st;
        tick();
        total++;
        if (payload_o_valid !== 1'b0 || res_payload_o !== '0) begin
            bad++;
            $display("FAIL link_clear got pv=%b data=%h want 0", payload_o_valid, res_payload_o);
        end
        send_rx(mk(8'h12, CMD_WRITE, 16'h0301, 32'h1, 1'b0), 1'b0);
        tick();
        total++;
        if (req_valid !== 1'b0 || rx_drop_cnt !== 8'(exp_drop)) begin
            bad++;
            $display("FAIL link_down_rx got rv=%b drop=%0d want 0/%0d", req_valid, rx_drop_cnt, exp_drop);
        end
        local_link_state = operational_st;
        repeat (2) tick();
        p = mk(8'h13, CMD_WRITE, 16'h0302, 32'h1357_9BDF, 1'b0);
        send_rx(p, 1'b0);
        total++;
        if (req_valid !== 1'b1 || req_data_channel !== p) begin
            bad++;
            $display("FAIL link_resume got rv=%b data=%h want 1/%h", req_valid, req_data_channel, p);
        end
        handshake();
        respond(mk(8'h00, CMD_WRITE, 16'h0302, 32'h0, 1'b0), 8'h13);
        wait_rise(ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || res_payload_o !== e) begin
            bad++;
            $display("FAIL link_post got %h want %h ok=%0d", res_payload_o, e, ok);
        end
        wait_fall(n, ok);
    endtask

`ifdef MGMT_DC_TARGET_TIMEOUT_EN
    task automatic test_timeout();
        Data_channel_payload_t p, e;
        int n;
        bit ok;
        p = mk(8'h44, CMD_READ, 16'h0400, 32'hFFFF_0000, 1'b0);
        e = p;
        e.data = '0;
        e.operation_status = 1'b1;
        exp_q.push_back(e);
        send_rx(p, 1'b0);
        repeat (TMO - 1) tick();
        total++;
        if (req_valid !== 1'b1) begin
            bad++;
            $display("FAIL to_early got rv=%b want 1", req_valid);
        end
        tick();
        total++;
        if (req_valid !== 1'b0) begin
            bad++;
            $display("FAIL to_deassert got rv=%b want 0", req_valid);
        end
        wait_rise(ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || res_payload_o !== e) begin
            bad++;
            $display("FAIL to_resp got %h want %h ok=%0d", res_payload_o, e, ok);
        end
        wait_fall(n, ok);
        p = mk(8'h45, CMD_READ, 16'h0404, 32'h0, 1'b0);
        send_rx(p, 1'b0);
        handshake();
        repeat (TMO - 2) tick();
        respond(mk(8'h45, CMD_READ, 16'h0404, 32'h2468_ACE0, 1'b0), 8'h45);
        wait_rise(ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || res_payload_o !== e) begin
            bad++;
            $display("FAIL to_race got %h want %h ok=%0d", res_payload_o, e, ok);
        end
        wait_fall(n, ok);
    endtask
`endif

    task automatic test_reset_mid();
        Data_channel_payload_t p, e;
        int n;
        bit ok;
        send_rx(mk(8'h50, CMD_WRITE, 16'h0500, 32'h1, 1'b0), 1'b0);
        reset = 1'b0;
        tick();
        exp_drop = 0;
        total++;
        if (req_valid !== 1'b0 || req_data_channel !== '0 || rx_drop_cnt !== 8'(exp_drop)) begin
            bad++;
            $display("FAIL rst_req got rv=%b data=%h drop=%0d want 0", req_valid, req_data_channel, rx_drop_cnt);
        end
        reset = 1'b1;
        tick();
        send_rx(mk(8'h51, CMD_READ, 16'h0504, 32'h0, 1'b0), 1'b0);
        handshake();
        respond(mk(8'h51, CMD_READ, 16'h0504, 32'h9999_8888, 1'b0), 8'h51);
        wait_rise(ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || res_payload_o !== e) begin
            bad++;
            $display("FAIL rst_pre got %h want %h ok=%0d", res_payload_o, e, ok);
        end
        repeat (2) tick();
        data_channel_rst = 1'b1;
        tick();
        data_channel_rst = 1'b0;
        total++;
        if (payload_o_valid !== 1'b0 || res_payload_o !== '0 || res_ack !== 1'b0 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL dcrst_clear got pv=%b data=%h ack=%b rv=%b want 0",
                     payload_o_valid, res_payload_o, res_ack, req_valid);
        end
        tick();
        p = mk(8'h52, CMD_WRITE, 16'h0508, 32'h7777_1111, 1'b0);
        send_rx(p, 1'b0);
        total++;
        if (req_valid !== 1'b1 || req_data_channel !== p) begin
            bad++;
            $display("FAIL dcrst_idle got rv=%b data=%h want 1/%h", req_valid, req_data_channel, p);
        end
        handshake();
        respond(mk(8'h52, CMD_WRITE, 16'h0508, 32'h0, 1'b0), 8'h52);
        wait_rise(ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || res_payload_o !== e) begin
            bad++;
            $display("FAIL dcrst_post got %h want %h ok=%0d", res_payload_o, e, ok);
        end
        wait_fall(n, ok);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_empty got %0d want 0", exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b0;
        payload_i = '0;
        payload_i_valid = 1'b0;
        frm_crc_error = 1'b0;
        req_ready = 1'b0;
        res_valid = 1'b0;
        res_data_channel = '0;
        local_link_state = operational_st;
        data_channel_rst = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        test_reset();
        test_write();
        test_crc();
        test_busy_drop();
        test_link_loss();
`ifdef MGMT_DC_TARGET_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
